// File: rtl/hsiao2_64_pkg.sv
// Shared constants for the Hsiao (72,64) SEC-DED encoder/decoder pair.
// H_COL[j] holds the check rows covered by data bit j; index 0 of each column is chk[0].
package hsiao2_64_pkg;

  localparam int DATA_W = 64;
  localparam int CHK_W  = 8;
  localparam int CODE_W = 72;

  // All 56 weight-3 columns plus eight weight-5 columns at j%8==3, chosen so
  // that every row covers exactly 26 data bits.
  localparam logic [0:CHK_W-1] H_COL [0:DATA_W-1] = '{
    8'hC4, 8'hE0, 8'hD0, 8'hBC, 8'hC8, 8'hC2, 8'hC1, 8'hB0,
    8'hA8, 8'hA4, 8'hA2, 8'h5E, 8'hA1, 8'h98, 8'h94, 8'h92,
    8'h91, 8'h8C, 8'h8A, 8'h2F, 8'h89, 8'h86, 8'h85, 8'h83,
    8'h70, 8'h68, 8'h64, 8'h97, 8'h62, 8'h61, 8'h58, 8'h54,
    8'h52, 8'h51, 8'h4C, 8'hCB, 8'h4A, 8'h49, 8'h46, 8'h45,
    8'h43, 8'h38, 8'h34, 8'hE5, 8'h32, 8'h31, 8'h2C, 8'h2A,
    8'h29, 8'h26, 8'h23, 8'hF2, 8'h1C, 8'h1A, 8'h19, 8'h16,
    8'h15, 8'h13, 8'h0E, 8'h79, 8'h0D, 8'h0B, 8'h07, 8'h25
  };

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/hsiao2_64_chkgen.sv
// Combinational check-bit generator: chk = data * H. Also usable as the
// data half of a syndrome computation.
module hsiao2_64_chkgen
  import hsiao2_64_pkg::*;
(
  input  logic [0:DATA_W-1] data,
  output logic [0:CHK_W-1]  chk
);

  always_comb begin
    chk = '0;
    for (int j = 0; j < DATA_W; j++) begin
      chk = chk ^ (data[j] ? H_COL[j] : '0);
    end
  end

endmodule

// File: rtl/hsiao2_64_enc.sv
// Streaming Hsiao (72,64) encoder with per-word error injection, a 2-entry
// skid buffer on the output and a saturating delivered-word counter.
module hsiao2_64_enc
  import hsiao2_64_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [0:DATA_W-1] i_data,
  input  logic [0:CODE_W-1] i_inj_mask,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [0:CODE_W-1] o_code,
  output logic [CNT_W-1:0]  o_word_cnt,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a word moves when valid and ready are both high at a rising
  // edge with enable high; valid never waits on ready, and o_ready is a flop.
  buf_state_t        state_q, state_d;
  logic [0:CODE_W-1] main_q, main_d;
  logic [0:CODE_W-1] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [0:CHK_W-1]  chk;
  logic [0:CODE_W-1] new_code;
  logic              it, ot;

  hsiao2_64_chkgen u_chkgen (
    .data (i_data),
    .chk  (chk)
  );

  // Mask goes on after check generation so check bits describe clean data.
  assign new_code = {i_data, chk} ^ i_inj_mask;

  assign it = enable & i_valid & ready_q;
  assign ot = enable & (state_q != BUF_EMPTY) & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    case (state_q)
      BUF_EMPTY: begin
        if (it) begin
          main_d  = new_code;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (it && !ot) begin
          skid_d  = new_code;
          state_d = BUF_TWO;
        end else if (!it && ot) begin
          state_d = BUF_EMPTY;
        end else if (it && ot) begin
          main_d = new_code;
        end
      end
      BUF_TWO: begin
        if (ot) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    ready_d = (state_d != BUF_TWO);
    if (ot && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = (state_q != BUF_EMPTY);
  assign o_code      = main_q;
  assign o_word_cnt  = cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_hsiao2_64_enc.sv
// Bench for hsiao2_64_enc: a queue-based reference of the accepted words and
// a row-parity check-bit model, with syndrome decoding of delivered codewords.
module tb_hsiao2_64_enc;
  import hsiao2_64_pkg::*;

  localparam int CNT_W = 5;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic              i_valid;
  logic              o_ready;
  logic [0:63]       i_data;
  logic [0:71]       i_inj_mask;
  logic              o_valid;
  logic              i_ready;
  logic [0:71]       o_code;
  logic [CNT_W-1:0]  o_word_cnt;
  logic [1:0]        o_dbg_state;

  hsiao2_64_enc #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_inj_mask  (i_inj_mask),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_code      (o_code),
    .o_word_cnt  (o_word_cnt),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [71:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_ready;
  logic [0:63]      row_mask [0:7];
  int               n_checks;
  int               n_fail;

  function automatic logic [0:71] model_code(input logic [0:63] d, input logic [0:71] m);
    logic [0:71] c;
    c = {d, 8'h00};
    for (int r = 0; r < 8; r++) c[64+r] = ^(d & row_mask[r]);
    return c ^ m;
  endfunction

  function automatic logic [0:7] syndrome(input logic [0:71] c);
    logic [0:7] s;
    logic [0:63] d;
    d = c[0:63];
    for (int r = 0; r < 8; r++) s[r] = (^(d & row_mask[r])) ^ c[64+r];
    return s;
  endfunction

  function automatic logic [0:7] column(input int j);
    logic [0:7] col;
    for (int r = 0; r < 8; r++) col[r] = row_mask[r][j];
    return col;
  endfunction

  function automatic logic [0:63] rand64();
    return {$urandom, $urandom};
  endfunction

  // driver: advance one clock and update the model from the handshake seen
  task automatic tick();
    logic it, ot;
    it = enable && i_valid && o_ready;
    ot = enable && o_valid && i_ready;
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      exp_cnt   = '0;
      exp_ready = 1'b0;
    end else begin
      if (ot) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      end
      if (it) exp_q.push_back(model_code(i_data, i_inj_mask));
      exp_ready = (exp_q.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    enable  = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_data = '0; i_inj_mask = '0;
    tick(); tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_code !== 72'h0 ||
        o_word_cnt !== '0 || o_dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b ready=%b code=%h cnt=%0d state=%0d, required 0 0 0 0 0",
               o_valid, o_ready, o_code, o_word_cnt, o_dbg_state);
    end
    reset_n = 1'b1; enable = 1'b1;
    tick();
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", o_ready);
    end
  endtask

  task automatic test_zero_word();
    i_ready = 1'b0; i_valid = 1'b1; i_data = '0; i_inj_mask = '0;
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_code !== 72'h0 || o_word_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL zero_word_latency: valid=%b code=%h cnt=%0d, required 1 0 0",
               o_valid, o_code, o_word_cnt);
    end
    i_ready = 1'b1;
    tick();
    n_checks++;
    if (o_word_cnt !== 5'd1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_word_count: cnt=%0d valid=%b, required 1 0", o_word_cnt, o_valid);
    end
  endtask

  task automatic test_known_chk();
    logic [0:7] got;
    i_ready = 1'b1; i_valid = 1'b1; i_inj_mask = '0;
    i_data = 64'h8000_0000_0000_0000;
    tick();
    got = o_code[64:71];
    n_checks++;
    if (got !== 8'hC4 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL chk_bit0: chk=%h valid=%b, required c4 1", got, o_valid);
    end
    i_data = '1;
    tick();
    got = o_code[64:71];
    n_checks++;
    if (got !== 8'h00 || o_code[0:63] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL chk_all_ones: code=%h, required ffffffffffffffff00", o_code);
    end
    drain();
  endtask

  task automatic test_walk();
    int w;
    i_ready = 1'b1; i_valid = 1'b1; i_inj_mask = '0;
    for (int j = 0; j < 64; j++) begin
      i_data = '0;
      i_data[j] = 1'b1;
      tick();
      w = $countones(o_code[64:71]);
      n_checks++;
      if (o_valid !== 1'b1 || exp_q.size() == 0 || o_code !== exp_q[0] ||
          syndrome(o_code) !== 8'h00 || w != (((j % 8) == 3) ? 5 : 3)) begin
        n_fail++;
        $display("FAIL walk_bit%0d: code=%h weight=%0d valid=%b, required %h",
                 j, o_code, w, o_valid, (exp_q.size() > 0) ? exp_q[0] : 72'hx);
      end
    end
    drain();
  endtask

  task automatic test_inject();
    logic [0:63] d;
    logic [0:71] c;
    logic [0:7]  s;
    int          hit;
    d = rand64();
    i_ready = 1'b1; i_valid = 1'b1; i_data = d;
    i_inj_mask = '0; i_inj_mask[10] = 1'b1;
    tick();
    i_valid = 1'b0;
    c = o_code;
    s = syndrome(c);
    hit = -1;
    for (int j = 0; j < 64; j++) if (column(j) == s) hit = j;
    if (hit >= 0) c[hit] = ~c[hit];
    n_checks++;
    if (o_code !== exp_q[0] || hit != 10 || c[0:63] !== d) begin
      n_fail++;
      $display("FAIL inject_single: code=%h syn=%h hit=%0d, required %h hit=10",
               o_code, s, hit, exp_q[0]);
    end
    tick();
    d = rand64();
    i_valid = 1'b1; i_data = d;
    i_inj_mask = '0; i_inj_mask[10] = 1'b1; i_inj_mask[40] = 1'b1;
    tick();
    i_valid = 1'b0;
    s = syndrome(o_code);
    n_checks++;
    if (o_code !== exp_q[0] || s == 8'h00 || (^s) !== 1'b0) begin
      n_fail++;
      $display("FAIL inject_double: code=%h syn=%h, required %h with even nonzero syndrome",
               o_code, s, exp_q[0]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [0:63] src_q[$];
    int          delivered;
    int          cyc;
    for (int k = 0; k < 5; k++) src_q.push_back(rand64());
    i_ready = 1'b0; i_inj_mask = '0;
    for (int k = 0; k < 6; k++) begin
      i_valid = (src_q.size() > 0);
      i_data  = src_q[0];
      if (i_valid && o_ready) begin
        tick(); void'(src_q.pop_front());
      end else tick();
    end
    n_checks++;
    if (o_ready !== 1'b0 || o_dbg_state !== 2'd2 || o_valid !== 1'b1 || o_code !== exp_q[0]) begin
      n_fail++;
      $display("FAIL backpressure_full: ready=%b state=%0d valid=%b code=%h, required 0 2 1 %h",
               o_ready, o_dbg_state, o_valid, o_code, exp_q[0]);
    end
    i_ready = 1'b1;
    delivered = 0;
    cyc = 0;
    while (delivered < 5 && cyc < 40) begin
      n_checks++;
      if (o_valid !== 1'b1 || exp_q.size() == 0 || o_code !== exp_q[0]) begin
        n_fail++;
        $display("FAIL release_order: word %0d valid=%b code=%h", delivered, o_valid, o_code);
      end
      i_valid = (src_q.size() > 0);
      i_data  = (src_q.size() > 0) ? src_q[0] : '0;
      if (i_valid && o_ready) begin
        tick(); void'(src_q.pop_front());
      end else tick();
      delivered++;
      cyc++;
    end
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_drained: valid=%b ready=%b, required 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_random_enable();
    logic [CNT_W-1:0] cnt_before;
    for (int k = 0; k < 300; k++) begin
      enable     = ($urandom_range(0, 3) != 0);
      i_valid    = $urandom_range(0, 1);
      i_ready    = ($urandom_range(0, 2) != 0);
      i_data     = rand64();
      i_inj_mask = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, 8'($urandom)} : '0;
      cnt_before = o_word_cnt;
      tick();
      n_checks++;
      if (o_valid !== (exp_q.size() > 0) || o_ready !== exp_ready || o_word_cnt !== exp_cnt ||
          (exp_q.size() > 0 && o_code !== exp_q[0])) begin
        n_fail++;
        $display("FAIL random_cycle%0d: valid=%b ready=%b cnt=%0d code=%h, required %b %b %0d %h",
                 k, o_valid, o_ready, o_word_cnt, o_code, exp_q.size() > 0, exp_ready,
                 exp_cnt, (exp_q.size() > 0) ? exp_q[0] : 72'hx);
      end
      if (!enable) begin
        n_checks++;
        if (o_word_cnt !== cnt_before) begin
          n_fail++;
          $display("FAIL disabled_hold%0d: cnt=%0d, required %0d", k, o_word_cnt, cnt_before);
        end
      end
    end
    drain();
  endtask

  task automatic test_saturation();
    i_ready = 1'b1; i_valid = 1'b1; i_inj_mask = '0; enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      i_data = rand64();
      tick();
    end
    i_valid = 1'b0;
    tick();
    n_checks++;
    if (o_word_cnt !== 5'd31) begin
      n_fail++;
      $display("FAIL counter_saturate: cnt=%0d, required 31", o_word_cnt);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0; i_valid = 1'b1; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = rand64();
      tick();
    end
    n_checks++;
    if (o_dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_mid_fill: state=%0d, required 2", o_dbg_state);
    end
    reset_n = 1'b0; enable = 1'b0;
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_word_cnt !== '0 || o_ready !== 1'b0 || o_code !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b cnt=%0d ready=%b code=%h, required 0 0 0 0",
               o_valid, o_word_cnt, o_ready, o_code);
    end
    reset_n = 1'b1; i_valid = 1'b0; enable = 1'b1;
    tick();
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release: ready=%b valid=%b, required 1 0", o_ready, o_valid);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_cnt   = '0;
    exp_ready = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 64; j++) row_mask[r][j] = H_COL[j][r];
    reset_n = 1'b0; enable = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_data = '0; i_inj_mask = '0;
    @(negedge clk);
    test_reset();
    test_zero_word();
    test_known_chk();
    test_walk();
    test_inject();
    test_back_to_back();
    test_random_enable();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hsiao2_64_enc.md
# hsiao2_64_enc

Streaming Hsiao (72,64) SEC-DED encoder. It is the transmit-side counterpart of the `hsiao2_64` decoder. The block accepts 64-bit data words on a valid/ready handshake, appends 8 check bits using the same H-matrix as the decoder, and can XOR a per-word error-injection mask into the codeword. The output is a 2-entry skid buffer, so both sides see registered handshakes at full throughput. It sits between the write-data source and storage or link, and feeds the decoder directly in loopback tests.

## Interface
- `CNT_W`, default 16: width of the saturating transferred-word counter.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  global advance qualifier; when low, no transfers occur and all state holds.
- `i_valid`  in  1  input word valid.
- `o_ready`  out  1  encoder can accept a word; registered.
- `i_data`  in  [0:63]  data word; bit 0 is the MSB, as in the decoder.
- `i_inj_mask`  in  [0:71]  error-injection mask, sampled with `i_data`; zero for normal traffic.
- `o_valid`  out  1  codeword valid.
- `i_ready`  in  1  downstream accepts the codeword.
- `o_code`  out  [0:71]  `{data[0:63], chk[0:7]} ^ mask`.
- `o_word_cnt`  out  [CNT_W-1:0]  output transfers since reset, saturating.

## Operation
- Input transfer (IT) = `enable & i_valid & o_ready`. Output transfer (OT) = `enable & o_valid & i_ready`.
- Check-bit rule: `chk[i]` = XOR over j of `i_data[j] & H_COL[j][i]`.
  - Every data column has weight 3, except columns 3, 11, 19, 27, 35, 43, 51 and 59, which have weight 5.
  - Every row covers 26 data bits.
- Example columns:
  - col 0 = rows {0,1,5}
  - col 3 = rows {0,2,3,4,5}
  - col 63 = rows {2,5,7}
- Codeword is computed on IT and stored pre-masked. The mask is applied after check-bit generation, so check bits always describe the unmasked data.
- Buffer states are EMPTY, ONE and TWO. ONE means the main register is full. TWO means main and skid are both full.
  - EMPTY, IT → ONE.
  - ONE: IT & !OT → TWO. !IT & OT → EMPTY. IT & OT → ONE, with main loaded with the new word.
  - TWO: OT → ONE, with skid moving to main. IT is impossible because `o_ready` = 0.
  - No other combination changes state.
- `o_valid` = state != EMPTY. `o_code` = main register.
- `o_ready` next = (next state != TWO). It is computed from the next state so that it stays registered.
- Words leave in acceptance order. No word is dropped or duplicated.
- `o_word_cnt` increments on OT and saturates at 2^CNT_W−1.

## Timing
- Latency: a word accepted on edge N is presented on `o_code` with `o_valid` = 1 after edge N, i.e. in cycle N+1, when the buffer was EMPTY.
- Throughput is 1 word/cycle while `i_ready` stays high.
- Values while `reset_n` is low at an edge:
  - state EMPTY
  - `o_valid` 0
  - `o_ready` 0
  - `o_code` 0
  - `o_word_cnt` 0
  - skid register 0
- `o_ready` rises on the first edge with `reset_n` high.
- Reset mid-operation discards all buffered words. It takes effect at the next edge regardless of `enable`.
- `enable` low: no IT or OT, and all registers hold. `i_valid` and `i_ready` are ignored that cycle.
- `o_code` must hold steady while `o_valid` = 1 and no OT occurs.
- Counter saturation and wrap-free behaviour must hold under continuous OT.

## Structure
- Package `hsiao2_64_pkg`:
  - `DATA_W` = 64, `CHK_W` = 8, `CODE_W` = 72.
  - `H_COL[0:63]` as 8-bit column constants, shared with the decoder.
  - The buffer-state enum.
- Sub-module `hsiao2_64_chkgen`: purely combinational, data [0:63] → chk [0:7], reused by the decoder's syndrome path.
- Top level contains the skid-buffer FSM, the mask XOR and the counter.

## Test plan
- After reset, send `i_data` = 64'h0 with mask 0 → `o_code` = 72'h0 one cycle later. `o_word_cnt` = 1 after OT.
- `i_data` = 1 at bit 0 only (64'h8000_0000_0000_0000), mask 0 → chk = 8'hC4. All-ones data → chk = 8'h00.
- Walk a single data bit over all 64 positions → each chk equals `H_COL[j]`. Each codeword through the decoder gives `o_err_detec` = 0.
- Mask with 1 bit at position 10 → decoder flags a correctable error and restores the data. Mask with 2 bits → decoder flags a fatal error.
- Hold `i_ready` = 0 while streaming 5 words → 2 words buffered and `o_ready` = 0. Release `i_ready` → all words delivered in order with no gaps.
- Assert `reset_n` = 0 with state TWO → next cycle `o_valid` = 0 and `o_word_cnt` = 0. Toggle `enable` during streaming → no transfer in the disabled cycles.
